// File: rtl/rcc_domain_wkup_seq_if.sv
// Wakeup/sleep requests and per-domain control outputs exchanged between the PWR side and the RCC sequencer.
interface rcc_domain_wkup_seq_if;
  logic pwr_d1_wkup;
  logic pwr_d2_wkup;
  logic pwr_d3_wkup;
  logic d1_sleep_req;
  logic d2_sleep_req;
  logic d3_sleep_req;
  logic hsi_rdy;
  logic err_clr;
  logic hsi_on_req;
  logic d1_clk_en;
  logic d2_clk_en;
  logic d3_clk_en;
  logic d1_rst_n;
  logic d2_rst_n;
  logic d3_rst_n;
  logic d1_rdy;
  logic d2_rdy;
  logic d3_rdy;
  logic err_osc_tmo;

  modport master (
    output pwr_d1_wkup, pwr_d2_wkup, pwr_d3_wkup,
    output d1_sleep_req, d2_sleep_req, d3_sleep_req,
    output hsi_rdy, err_clr,
    input  hsi_on_req,
    input  d1_clk_en, d2_clk_en, d3_clk_en,
    input  d1_rst_n, d2_rst_n, d3_rst_n,
    input  d1_rdy, d2_rdy, d3_rdy,
    input  err_osc_tmo
  );

  modport slave (
    input  pwr_d1_wkup, pwr_d2_wkup, pwr_d3_wkup,
    input  d1_sleep_req, d2_sleep_req, d3_sleep_req,
    input  hsi_rdy, err_clr,
    output hsi_on_req,
    output d1_clk_en, d2_clk_en, d3_clk_en,
    output d1_rst_n, d2_rst_n, d3_rst_n,
    output d1_rdy, d2_rdy, d3_rdy,
    output err_osc_tmo
  );
endinterface

// File: rtl/rcc_domain_wkup_seq.sv
// Per-domain D1/D2/D3 power sequencer: wake -> HSI -> clocks -> reset release -> ready, D3 as backbone.
// Wake reaches the FSM 3 clk after first sample; outputs registered; no backpressure (sleep_req is a held level).
module rcc_domain_wkup_seq #(
  parameter int CLK_DLY = 4,
  parameter int RST_DLY = 8,
  parameter int OSC_TMO = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  rcc_domain_wkup_seq_if.slave  bus
);
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OSC_WAIT = 3'd1,
    ST_CLK_ON   = 3'd2,
    ST_RST_REL  = 3'd3,
    ST_ACTIVE   = 3'd4,
    ST_RST_ON   = 3'd5
  } state_e;

  localparam int CNT_MAX = (OSC_TMO > CLK_DLY) ? ((OSC_TMO > RST_DLY) ? OSC_TMO : RST_DLY)
                                               : ((CLK_DLY > RST_DLY) ? CLK_DLY : RST_DLY);
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] OSC_LAST = CW'(OSC_TMO - 1);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLK_DLY - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_DLY - 1);
  localparam int D3 = 2;

  logic [2:0]    wkup_raw;
  logic [2:0]    sleep_req;
  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [2:0]    wake_q, wake_d;
  logic [2:0]    pend_q, pend_d;
  state_e        state_q [3];
  state_e        state_d [3];
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    clk_en_q, clk_en_d;
  logic [2:0]    rst_n_q, rst_n_d;
  logic [2:0]    rdy_q, rdy_d;
  logic          hsi_on_req_q, hsi_on_req_d;
  logic          err_osc_tmo_q, err_osc_tmo_d;
  logic [2:0]    go;
  logic [2:0]    wake_ev;
  logic [2:0]    tmo;
  logic          d3_act;
  logic          d3_sleep_ok;

  assign wkup_raw  = {bus.pwr_d3_wkup, bus.pwr_d2_wkup, bus.pwr_d1_wkup};
  assign sleep_req = {bus.d3_sleep_req, bus.d2_sleep_req, bus.d1_sleep_req};

  always_comb begin
    sync1_d = wkup_raw;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    wake_d  = sync2_q & ~sync3_q;

    d3_act = (state_q[D3] == ST_ACTIVE);
    go[0]  = (state_q[0] == ST_IDLE) && (wake_q[0] || pend_q[0]);
    go[1]  = (state_q[1] == ST_IDLE) && (wake_q[1] || pend_q[1]);
    // D1/D2 leaving IDLE drags the backbone along, or queues it behind an ongoing D3 power-down.
    go[2]  = (state_q[2] == ST_IDLE) && (wake_q[2] || pend_q[2] || go[0] || go[1]);
    wake_ev = {wake_q[2] || go[0] || go[1], wake_q[1], wake_q[0]};
    d3_sleep_ok = (state_q[0] == ST_IDLE) && (state_q[1] == ST_IDLE) && !go[0] && !go[1];

    tmo      = '0;
    pend_d   = '0;
    clk_en_d = '0;
    rst_n_d  = '0;
    rdy_d    = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pend_d[i]  = (state_q[i] == ST_RST_ON) && (pend_q[i] || wake_ev[i]);
      case (state_q[i])
        ST_IDLE: begin
          if (go[i]) begin
            state_d[i] = ST_OSC_WAIT;
            cnt_d[i]   = '0;
          end
        end
        ST_OSC_WAIT: begin
          if (bus.hsi_rdy && (i == D3 || d3_act)) begin
            state_d[i] = ST_CLK_ON;
            cnt_d[i]   = '0;
          end else if (!bus.hsi_rdy) begin
            if (cnt_q[i] == OSC_LAST) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
              tmo[i]     = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
        ST_CLK_ON: begin
          if (cnt_q[i] == CLK_LAST) begin
            state_d[i] = ST_RST_REL;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        ST_RST_REL: begin
          if (cnt_q[i] == RST_LAST) begin
            state_d[i] = ST_ACTIVE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        ST_ACTIVE: begin
          if (sleep_req[i] && (i != D3 || d3_sleep_ok)) begin
            state_d[i] = ST_RST_ON;
            cnt_d[i]   = '0;
          end
        end
        ST_RST_ON: begin
          if (cnt_q[i] == RST_LAST) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      clk_en_d[i] = state_d[i] inside {ST_CLK_ON, ST_RST_REL, ST_ACTIVE, ST_RST_ON};
      rst_n_d[i]  = state_d[i] inside {ST_RST_REL, ST_ACTIVE};
      rdy_d[i]    = (state_d[i] == ST_ACTIVE);
    end

    hsi_on_req_d  = (state_q[0] != ST_IDLE) || (state_q[1] != ST_IDLE) || (state_q[2] != ST_IDLE);
    err_osc_tmo_d = (|tmo) ? 1'b1 : (bus.err_clr ? 1'b0 : err_osc_tmo_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      sync3_q       <= '0;
      wake_q        <= '0;
      pend_q        <= '0;
      clk_en_q      <= '0;
      rst_n_q       <= '0;
      rdy_q         <= '0;
      hsi_on_req_q  <= 1'b0;
      err_osc_tmo_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync3_q       <= sync3_d;
      wake_q        <= wake_d;
      pend_q        <= pend_d;
      clk_en_q      <= clk_en_d;
      rst_n_q       <= rst_n_d;
      rdy_q         <= rdy_d;
      hsi_on_req_q  <= hsi_on_req_d;
      err_osc_tmo_q <= err_osc_tmo_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.hsi_on_req  = hsi_on_req_q;
  assign bus.d1_clk_en   = clk_en_q[0];
  assign bus.d2_clk_en   = clk_en_q[1];
  assign bus.d3_clk_en   = clk_en_q[2];
  assign bus.d1_rst_n    = rst_n_q[0];
  assign bus.d2_rst_n    = rst_n_q[1];
  assign bus.d3_rst_n    = rst_n_q[2];
  assign bus.d1_rdy      = rdy_q[0];
  assign bus.d2_rdy      = rdy_q[1];
  assign bus.d3_rdy      = rdy_q[2];
  assign bus.err_osc_tmo = err_osc_tmo_q;
endmodule

// File: tb/tb_rcc_domain_wkup_seq.sv
// Directed bench for rcc_domain_wkup_seq: a phase/countdown model of the sequencing rules checked
// every cycle, plus literal cycle-exact expectations for the documented scenarios.
module tb_rcc_domain_wkup_seq;
  localparam int CLK_DLY = 4;
  localparam int RST_DLY = 8;
  localparam int OSC_TMO = 64;
  localparam int P_IDLE = 0, P_OSC = 1, P_CLK = 2, P_REL = 3, P_ACT = 4, P_RON = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] wkup = '0;
  logic [2:0] sleep = '0;
  logic       hsi_rdy = 1'b0;
  logic       err_clr = 1'b0;
  int         n_chk = 0;
  int         n_err = 0;
  bit         cmp_en = 1'b0;

  rcc_domain_wkup_seq_if bus();
  assign bus.pwr_d1_wkup  = wkup[0];
  assign bus.pwr_d2_wkup  = wkup[1];
  assign bus.pwr_d3_wkup  = wkup[2];
  assign bus.d1_sleep_req = sleep[0];
  assign bus.d2_sleep_req = sleep[1];
  assign bus.d3_sleep_req = sleep[2];
  assign bus.hsi_rdy      = hsi_rdy;
  assign bus.err_clr      = err_clr;

  rcc_domain_wkup_seq #(.CLK_DLY(CLK_DLY), .RST_DLY(RST_DLY), .OSC_TMO(OSC_TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: domain phase, remaining cycles in timed phases, cycles waited on HSI, and the cycle
  // at which a sampled wake rising edge takes effect (three edges after first being sampled).
  int ph[3]     = '{0, 0, 0};
  int rem[3]    = '{0, 0, 0};
  int waited[3] = '{0, 0, 0};
  int due[3]    = '{-1, -1, -1};
  bit pend[3]   = '{0, 0, 0};
  bit prev_raw[3] = '{0, 0, 0};
  bit m_hsi = 1'b0;
  bit m_err = 1'b0;
  int cyc = 0;

  always @(posedge clk) begin : model
    int oph[3];
    bit ev[3];
    bit st[3];
    bit dep;
    bit tmo;
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        ph[d] = P_IDLE; rem[d] = 0; waited[d] = 0; pend[d] = 1'b0; due[d] = -1; prev_raw[d] = 1'b0;
      end
      m_hsi = 1'b0;
      m_err = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        oph[d] = ph[d];
        ev[d]  = 1'b0;
        if (wkup[d] && !prev_raw[d]) due[d] = cyc + 3;
        prev_raw[d] = wkup[d];
        if (due[d] == cyc) begin
          ev[d]  = 1'b1;
          due[d] = -1;
        end
      end
      for (int d = 0; d < 3; d++) st[d] = (oph[d] == P_IDLE) && (ev[d] || pend[d]);
      dep = st[0] || st[1];
      if (oph[2] == P_IDLE && dep) st[2] = 1'b1;
      m_hsi = (oph[0] != P_IDLE) || (oph[1] != P_IDLE) || (oph[2] != P_IDLE);
      tmo = 1'b0;
      for (int d = 0; d < 3; d++) begin
        case (oph[d])
          P_IDLE: if (st[d]) begin ph[d] = P_OSC; waited[d] = 0; pend[d] = 1'b0; end
          P_OSC: begin
            if (hsi_rdy && (d == 2 || oph[2] == P_ACT)) begin
              ph[d] = P_CLK; rem[d] = CLK_DLY;
            end else if (!hsi_rdy) begin
              waited[d]++;
              if (waited[d] == OSC_TMO) begin ph[d] = P_IDLE; tmo = 1'b1; end
            end
          end
          P_CLK: begin rem[d]--; if (rem[d] == 0) begin ph[d] = P_REL; rem[d] = RST_DLY; end end
          P_REL: begin rem[d]--; if (rem[d] == 0) ph[d] = P_ACT; end
          P_ACT: begin
            if (sleep[d] && (d != 2 || (oph[0] == P_IDLE && oph[1] == P_IDLE && !dep))) begin
              ph[d] = P_RON; rem[d] = RST_DLY;
            end
          end
          P_RON: begin
            if (ev[d] || (d == 2 && dep)) pend[d] = 1'b1;
            rem[d]--;
            if (rem[d] == 0) ph[d] = P_IDLE;
          end
          default: ph[d] = P_IDLE;
        endcase
      end
      if (tmo) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    logic [2:0] e_clk, e_rstn, e_rdy, a_clk, a_rstn, a_rdy;
    if (cmp_en) begin
      for (int d = 0; d < 3; d++) begin
        e_clk[d]  = (ph[d] != P_IDLE) && (ph[d] != P_OSC);
        e_rstn[d] = (ph[d] == P_REL) || (ph[d] == P_ACT);
        e_rdy[d]  = (ph[d] == P_ACT);
      end
      a_clk  = {bus.d3_clk_en, bus.d2_clk_en, bus.d1_clk_en};
      a_rstn = {bus.d3_rst_n, bus.d2_rst_n, bus.d1_rst_n};
      a_rdy  = {bus.d3_rdy, bus.d2_rdy, bus.d1_rdy};
      chk("model_hsi_on_req", 32'(bus.hsi_on_req), 32'(m_hsi));
      chk("model_clk_en", 32'(a_clk), 32'(e_clk));
      chk("model_rst_n", 32'(a_rstn), 32'(e_rstn));
      chk("model_rdy", 32'(a_rdy), 32'(e_rdy));
      chk("model_err_osc_tmo", 32'(bus.err_osc_tmo), 32'(m_err));
      chk("d1d2_rst_n_without_d3_rdy", 32'((|a_rstn[1:0]) & ~a_rdy[2]), 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int d);
    wkup[d] = 1'b1;
    step(1);
    wkup[d] = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_hsi"}, 32'(bus.hsi_on_req), 0);
    chk({tag, "_clk_en"}, 32'({bus.d3_clk_en, bus.d2_clk_en, bus.d1_clk_en}), 0);
    chk({tag, "_rst_n"}, 32'({bus.d3_rst_n, bus.d2_rst_n, bus.d1_rst_n}), 0);
    chk({tag, "_rdy"}, 32'({bus.d3_rdy, bus.d2_rdy, bus.d1_rdy}), 0);
    chk({tag, "_err"}, 32'(bus.err_osc_tmo), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1;
    step(1);
    cmp_en = 1'b1;
    step(2);
    outs_zero("reset");
    rst = 1'b0;
    hsi_rdy = 1'b1;

    // Scenario 1: D3 alone, pulse sampled at edge E.
    pulse(2);
    step(3);
    chk("t1_d3_clk_en_e3", 32'(bus.d3_clk_en), 0);
    chk("t1_hsi_e3", 32'(bus.hsi_on_req), 0);
    step(1);
    chk("t1_d3_clk_en_e4", 32'(bus.d3_clk_en), 1);
    chk("t1_d3_rst_n_e4", 32'(bus.d3_rst_n), 0);
    chk("t1_hsi_e4", 32'(bus.hsi_on_req), 1);
    step(3);
    chk("t1_d3_rst_n_e7", 32'(bus.d3_rst_n), 0);
    step(1);
    chk("t1_d3_rst_n_e8", 32'(bus.d3_rst_n), 1);
    chk("t1_d3_rdy_e8", 32'(bus.d3_rdy), 0);
    step(7);
    chk("t1_d3_rdy_e15", 32'(bus.d3_rdy), 0);
    step(1);
    chk("t1_d3_rdy_e16", 32'(bus.d3_rdy), 1);

    // Return D3 to IDLE.
    sleep[2] = 1'b1;
    step(1);
    chk("sleep3_rst_n", 32'(bus.d3_rst_n), 0);
    chk("sleep3_clk_on", 32'(bus.d3_clk_en), 1);
    sleep[2] = 1'b0;
    step(10);
    chk("sleep3_clk_off", 32'(bus.d3_clk_en), 0);
    chk("sleep3_hsi_off", 32'(bus.hsi_on_req), 0);

    // Scenario 2: D1 wake pulls D3 up first.
    pulse(0);
    step(3);
    chk("t2_d1_clk_en_e3", 32'(bus.d1_clk_en), 0);
    step(13);
    chk("t2_d3_rdy_e16", 32'(bus.d3_rdy), 1);
    chk("t2_d1_clk_en_e16", 32'(bus.d1_clk_en), 0);
    step(1);
    chk("t2_d1_clk_en_e17", 32'(bus.d1_clk_en), 1);
    chk("t2_d1_rst_n_e17", 32'(bus.d1_rst_n), 0);
    step(4);
    chk("t2_d1_rst_n_e21", 32'(bus.d1_rst_n), 1);
    step(7);
    chk("t2_d1_rdy_e28", 32'(bus.d1_rdy), 0);
    step(1);
    chk("t2_d1_rdy_e29", 32'(bus.d1_rdy), 1);

    // Scenario 4: D3 sleep blocked by D1, then D1 sleep releases it.
    sleep[2] = 1'b1;
    step(10);
    chk("t4_d3_sleep_ignored", 32'(bus.d3_rdy), 1);
    sleep[0] = 1'b1;
    step(1);
    chk("t4_d1_rst_n_s0", 32'(bus.d1_rst_n), 0);
    chk("t4_d1_clk_en_s0", 32'(bus.d1_clk_en), 1);
    chk("t4_d1_rdy_s0", 32'(bus.d1_rdy), 0);
    step(7);
    chk("t4_d1_clk_en_s7", 32'(bus.d1_clk_en), 1);
    chk("t4_d3_rdy_s7", 32'(bus.d3_rdy), 1);
    step(1);
    chk("t4_d1_clk_en_s8", 32'(bus.d1_clk_en), 0);
    chk("t4_d3_rdy_s8", 32'(bus.d3_rdy), 1);
    step(1);
    chk("t4_d3_rdy_s9", 32'(bus.d3_rdy), 0);
    chk("t4_d3_clk_en_s9", 32'(bus.d3_clk_en), 1);
    chk("t4_d3_rst_n_s9", 32'(bus.d3_rst_n), 0);
    sleep = '0;

    // Scenario 5: D3 wake during RST_ON is held until the power-down completes.
    pulse(2);
    step(6);
    chk("t5_d3_clk_en_s16", 32'(bus.d3_clk_en), 1);
    chk("t5_d3_rst_n_s16", 32'(bus.d3_rst_n), 0);
    step(1);
    chk("t5_d3_clk_en_s17", 32'(bus.d3_clk_en), 0);
    step(1);
    chk("t5_d3_clk_en_s18", 32'(bus.d3_clk_en), 0);
    chk("t5_hsi_s18", 32'(bus.hsi_on_req), 0);
    step(1);
    chk("t5_d3_clk_en_s19", 32'(bus.d3_clk_en), 1);
    chk("t5_hsi_s19", 32'(bus.hsi_on_req), 1);
    step(11);
    chk("t5_d3_rdy_s30", 32'(bus.d3_rdy), 0);
    step(1);
    chk("t5_d3_rdy_s31", 32'(bus.d3_rdy), 1);

    // Scenario 6: reset during D2 RST_REL, then a fresh full sequence.
    pulse(1);
    step(10);
    chk("t6_d2_rst_n_e10", 32'(bus.d2_rst_n), 1);
    chk("t6_d2_rdy_e10", 32'(bus.d2_rdy), 0);
    rst = 1'b1;
    step(1);
    outs_zero("t6_rst");
    rst = 1'b0;
    step(2);
    pulse(1);
    step(16);
    chk("t6_d3_rdy_e16", 32'(bus.d3_rdy), 1);
    chk("t6_d2_clk_en_e16", 32'(bus.d2_clk_en), 0);
    step(12);
    chk("t6_d2_rdy_e28", 32'(bus.d2_rdy), 0);
    step(1);
    chk("t6_d2_rdy_e29", 32'(bus.d2_rdy), 1);

    // Scenario 3: HSI never ready, D2+D3 time out.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    hsi_rdy = 1'b0;
    step(1);
    pulse(1);
    step(66);
    chk("t3_err_e66", 32'(bus.err_osc_tmo), 0);
    chk("t3_hsi_e66", 32'(bus.hsi_on_req), 1);
    step(1);
    chk("t3_err_e67", 32'(bus.err_osc_tmo), 1);
    chk("t3_hsi_e67", 32'(bus.hsi_on_req), 1);
    step(1);
    chk("t3_hsi_e68", 32'(bus.hsi_on_req), 0);
    step(5);
    chk("t3_err_sticky", 32'(bus.err_osc_tmo), 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("t3_err_cleared", 32'(bus.err_osc_tmo), 0);

    // Timeout coinciding with err_clr: the set wins.
    pulse(2);
    step(66);
    err_clr = 1'b1;
    step(1);
    chk("t3_set_wins", 32'(bus.err_osc_tmo), 1);
    step(1);
    chk("t3_clr_after", 32'(bus.err_osc_tmo), 0);
    err_clr = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
